// File: rtl/common_pkg.sv
// common_pkg: shared word width for the SPI datapath
package common_pkg;
    localparam int DATA_WIDTH = 8;
endpackage

// File: rtl/spi_controller_if.sv
// spi_controller_if: word-level request/response handshake of spi_controller
interface spi_controller_if;
    import common_pkg::*;
    logic                  valid_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  last_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  done_o;
    modport master(output valid_i, data_i, last_i, input ready_o, data_o, done_o);
    modport slave(input valid_i, data_i, last_i, output ready_o, data_o, done_o);
endinterface

// File: rtl/spi_controller.sv
// spi_controller: SPI mode 0 master, one word per request, CS held low across words until last
module spi_controller
    import common_pkg::*;
#(
    parameter int HALF_PERIOD = 2
) (
    input  logic sys_clk_i,
    input  logic sys_reset_ni,
    spi_controller_if.slave bus,
    output logic spi_cs_no,
    output logic spi_sck_o,
    output logic spi_sd_o,
    input  logic spi_sd_i
);
    localparam int CW = $clog2(HALF_PERIOD + 1);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, WAIT, HOLD, GAP} state_t;

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bits;
    logic [DATA_WIDTH-1:0] shreg, rx, data_q;
    logic last_q, done_q, accept, tick, fall, last_bit, fin;

    always_ff @(posedge sys_clk_i) begin
        if (!sys_reset_ni) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, WAIT: nxt = bus.valid_i ? SETUP : state;
            SETUP, LOW: nxt = tick ? HIGH : state;
            HIGH:       nxt = !tick ? HIGH : !last_bit ? LOW : last_q ? HOLD : WAIT;
            HOLD:       nxt = tick ? GAP : HOLD;
            GAP:        nxt = tick ? IDLE : GAP;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ready_o = state == IDLE || state == WAIT;
        accept = bus.ready_o && bus.valid_i;
        tick = cnt == '0;
        fall = state == HIGH && tick;
        last_bit = bits == BW'(DATA_WIDTH - 1);
        fin = fall && last_bit;
        rx = {shreg[DATA_WIDTH-2:0], spi_sd_i};
    end

    // SPI pins are registered from the next state so they switch on the same edge as the FSM
    always_ff @(posedge sys_clk_i) begin
        if (!sys_reset_ni) begin
            cnt <= '0;
            bits <= '0;
            shreg <= '0;
            last_q <= 1'b0;
            spi_cs_no <= 1'b1;
            spi_sck_o <= 1'b0;
            spi_sd_o <= 1'b0;
            done_q <= 1'b0;
            data_q <= '0;
        end else begin
            cnt <= nxt != state ? CNT_LOAD : tick ? cnt : cnt - 1'b1;
            spi_sck_o <= nxt == HIGH;
            spi_cs_no <= nxt == IDLE || nxt == GAP;
            done_q <= fin;
            if (accept) begin
                shreg <= bus.data_i;
                last_q <= bus.last_i;
                bits <= '0;
                spi_sd_o <= bus.data_i[DATA_WIDTH-1];
            end else if (fall) begin
                shreg <= rx;
                bits <= bits + 1'b1;
                spi_sd_o <= last_bit ? 1'b0 : shreg[DATA_WIDTH-2];
            end
            if (fin) data_q <= rx;
        end
    end

    assign bus.data_o = data_q;
    assign bus.done_o = done_q;
endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 2, meaning sys_clk_i cycles per SCK half-period (legal range >= 1).
REQ-002 SHALL have port sys_clk_i  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port sys_reset_ni  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port valid_i  input  1  request to transfer one word.
REQ-005 SHALL have port data_i  input  DATA_WIDTH  word to transmit, MSB first.
REQ-006 SHALL have port last_i  input  1  deassert CS after this word.
REQ-007 SHALL have port ready_o  output  1  request accepted on a cycle with valid_i && ready_o.
REQ-008 SHALL have port data_o  output  DATA_WIDTH  word received.
REQ-009 SHALL have port done_o  output  1  one-cycle strobe; data_o valid.
REQ-010 SHALL have port spi_cs_no  output  1  chip select, active low.
REQ-011 SHALL have port spi_sck_o  output  1  serial clock, idle low.
REQ-012 SHALL have port spi_sd_o  output  1  serial data out (SDO).
REQ-013 SHALL have port spi_sd_i  input  1  serial data in (SDI).

Function
REQ-014 SHALL implement SPI Mode 0: CPOL=0, CPHA=0; SDO changes only while SCK low; SDI captured at end of each SCK-high phase.
REQ-015 SHALL use states IDLE (CS high), SETUP, HIGH, LOW, WAIT (CS low, between words), HOLD, GAP.
REQ-016 SHALL assert ready_o only in IDLE and WAIT.
REQ-017 On acceptance at edge 0 SHALL load data_i into shift register, capture last_i, drive spi_cs_no=0, present data_i[MSB] on spi_sd_o, and enter SETUP.
REQ-018 SETUP, HIGH and LOW SHALL each last exactly HALF_PERIOD cycles, timed by a down-counter.
REQ-019 spi_sck_o SHALL rise at edges H, 3H, ..., 15H (H=HALF_PERIOD) and fall at 2H, 4H, ..., 16H.
REQ-020 At each falling edge SHALL shift spi_sd_i into the shift-register LSB and, except the 8th, present the next bit on spi_sd_o.
REQ-021 At edge 16H SHALL update data_o with the received word and pulse done_o for exactly one cycle; data_o SHALL hold until the next done_o.
REQ-022 If captured last_i=0, SHALL enter WAIT at edge 16H, holding CS low, SCK low, ready_o=1; the next acceptance follows REQ-017 with the same timing.
REQ-023 If captured last_i=1, SHALL enter HOLD for H cycles, raise spi_cs_no at edge 17H, stay in GAP for H cycles, and return to IDLE (ready_o=1) at edge 18H.
REQ-024 valid_i while ready_o=0 SHALL be ignored; data_i and last_i SHALL be sampled only on acceptance.
REQ-025 spi_sd_o SHALL equal 0 while spi_cs_no=1.
REQ-026 All SPI outputs SHALL be registered, with no combinational path from inputs.

Reset
REQ-027 While sys_reset_ni=0 at a clock edge: state IDLE, spi_cs_no=1, spi_sck_o=0, spi_sd_o=0, done_o=0, ready_o=1, data_o=0.
REQ-028 Reset mid-transfer SHALL abort immediately; the next cycle shows CS high with no done_o; the partial word is discarded.

Structure
REQ-029 SHALL import DATA_WIDTH from common_pkg; the state enum SHALL stay local to the module.
REQ-030 SHALL be a single module with no sub-modules; the half-period counter width SHALL be $clog2(HALF_PERIOD+1).

Verification
REQ-031 H=2, send 0xA5 last=1, loopback SDO->SDI -> 8 SCK pulses of 4 cycles; data_o=0xA5 with done_o at cycle 32; CS rises at 34; ready_o at 36.
REQ-032 H=1, peripheral model returns 0x3C for sent 0xC3 -> data_o=0x3C; SDO bits 1,1,0,0,0,0,1,1 stable across every rising SCK.
REQ-033 Two words 0x12 (last=0), 0x34 (last=1) -> CS stays low between words; two done_o pulses; data_o 0x12 then 0x34.
REQ-034 Assert sys_reset_ni=0 after 3rd SCK rise -> next cycle CS=1, SCK=0, no done_o; a following transfer completes correctly.
REQ-035 valid_i toggled with data changing while ready_o=0 -> no extra transfer; transmitted word equals the value at acceptance.
